// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared constants, FSM state type and slot index width helper
package spdif_pkg;

  localparam int AUDIO_W      = 20;
  localparam int AUX_W        = 4;
  localparam int BLOCK_FRAMES = 192;

  typedef enum logic [1:0] {
    WAIT_A,
    COLLECT,
    PUSH
  } frame_state_t;

  function automatic int slot_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/spdif_sync_fifo.sv
// rtl/spdif_sync_fifo.sv - first-word-fall-through FIFO with fill, full and empty
module spdif_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  // The extra pointer bit distinguishes a full ring from an empty one.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);
  assign fill    = wr_ptr_q - rd_ptr_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spdif_frame_fifo.sv
// rtl/spdif_frame_fifo.sv - packs subframes into frame words and buffers them for the consumer
module spdif_frame_fifo
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vin,
  input  logic [19:0]                    din,
  input  logic                           vauxin,
  input  logic [3:0]                     dauxin,
  input  logic                           in_channel,
  input  logic                           block_start,
  input  logic                           kill,
  output logic [CHANNELS*SAMPLE_W-1:0]   dout,
  output logic                           dout_block,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [$clog2(DEPTH):0]         fill,
  output logic                           overflow,
  output logic [7:0]                     misalign_cnt,
  output logic [7:0]                     level
);

  localparam int SW      = slot_idx_w(CHANNELS);
  localparam int FRAME_W = CHANNELS * SAMPLE_W;

  frame_state_t         state_q, state_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 block_q, block_d;
  logic [AUX_W-1:0]     aux_q, aux_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           misalign_q, misalign_d;
  logic [7:0]           level_q, level_d;

  logic [SAMPLE_W-1:0]  sample;
  logic                 start_frame;
  logic [7:0]           mis_inc;
  logic [8:0]           mis_sum;
  logic                 push_req;
  logic                 push_ok;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FRAME_W:0]     fifo_rd_data;

  if (SAMPLE_W == AUDIO_W + AUX_W) begin : g_with_aux
    assign sample = {din, aux_q};
  end else begin : g_audio_only
    assign sample = din;
  end

  assign pop     = !fifo_empty && dout_ready;
  assign push_ok = push_req && (!fifo_full || pop);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    frame_d     = frame_q;
    block_d     = block_q;
    aux_d       = aux_q;
    start_frame = 1'b0;
    mis_inc     = '0;
    push_req    = (state_q == PUSH);

    if (vin)    aux_d = '0;
    if (vauxin) aux_d = dauxin;

    if (state_q == PUSH) state_d = WAIT_A;

    // Kill in PUSH still lets the push through; it only suppresses this cycle's vin.
    if (kill) begin
      state_d = WAIT_A;
      slot_d  = '0;
    end else if (vin) begin
      if (state_q == COLLECT) begin
        if (in_channel) begin
          frame_d[int'(slot_q)*SAMPLE_W +: SAMPLE_W] = sample;
          if (slot_q == SW'(CHANNELS-1)) begin
            state_d = PUSH;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          mis_inc     = 8'(slot_q);
          start_frame = 1'b1;
        end
      end else if (!in_channel) begin
        start_frame = 1'b1;
      end else begin
        mis_inc = 8'd1;
      end
    end

    if (start_frame) begin
      frame_d[SAMPLE_W-1:0] = sample;
      block_d               = block_start;
      slot_d                = SW'(1);
      state_d               = (CHANNELS == 1) ? PUSH : COLLECT;
    end

    mis_sum    = {1'b0, misalign_q} + {1'b0, mis_inc};
    misalign_d = mis_sum[8] ? 8'hFF : mis_sum[7:0];
    overflow_d = overflow_q | (push_req && !push_ok);
    level_d    = push_ok ? frame_q[SAMPLE_W-1 -: 8] : level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT_A;
      slot_q     <= '0;
      frame_q    <= '0;
      block_q    <= 1'b0;
      aux_q      <= '0;
      overflow_q <= 1'b0;
      misalign_q <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      block_q    <= block_d;
      aux_q      <= aux_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
      level_q    <= level_d;
    end
  end

  spdif_sync_fifo #(
    .WIDTH (FRAME_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_ok),
    .wr_data ({block_q, frame_q}),
    .rd_en   (dout_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (fill)
  );

  assign dout         = fifo_rd_data[FRAME_W-1:0];
  assign dout_block   = fifo_rd_data[FRAME_W];
  assign dout_valid   = !fifo_empty;
  assign overflow     = overflow_q;
  assign misalign_cnt = misalign_q;
  assign level        = level_q;

endmodule

// File: tb/tb_spdif_frame_fifo.sv
// tb/tb_spdif_frame_fifo.sv - directed scoreboard bench for spdif_frame_fifo
module tb_spdif_frame_fifo;

  localparam int SAMPLE_W = 24;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 4;
  localparam int FW       = SAMPLE_W * CHANNELS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vin = 1'b0;
  logic [19:0]   din = '0;
  logic          vauxin = 1'b0;
  logic [3:0]    dauxin = '0;
  logic          in_channel = 1'b0;
  logic          block_start = 1'b0;
  logic          kill = 1'b0;
  logic [FW-1:0] dout;
  logic          dout_block;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [2:0]    fill;
  logic          overflow;
  logic [7:0]    misalign_cnt;
  logic [7:0]    level;

  int total = 0;
  int bad   = 0;
  logic [FW:0] sb[$];
  logic [FW:0] exp_word;

  always #5 clk = ~clk;

  spdif_frame_fifo #(
    .SAMPLE_W (SAMPLE_W),
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vin          (vin),
    .din          (din),
    .vauxin       (vauxin),
    .dauxin       (dauxin),
    .in_channel   (in_channel),
    .block_start  (block_start),
    .kill         (kill),
    .dout         (dout),
    .dout_block   (dout_block),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .fill         (fill),
    .overflow     (overflow),
    .misalign_cnt (misalign_cnt),
    .level        (level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic send_sub(input bit use_aux, input logic [3:0] aux, input logic [19:0] d,
                          input logic ch, input logic blk);
    if (use_aux) begin
      vauxin = 1'b1;
      dauxin = aux;
      tick();
      vauxin = 1'b0;
    end
    vin         = 1'b1;
    din         = d;
    in_channel  = ch;
    block_start = blk;
    tick();
    vin         = 1'b0;
    block_start = 1'b0;
  endtask

  // Returns in the PUSH cycle of the frame; the expected word is queued only if it should be stored.
  task automatic send_frame(input bit use_aux, input logic [3:0] aux_a, input logic [19:0] din_a,
                            input logic [3:0] aux_b, input logic [19:0] din_b,
                            input logic blk, input bit expect_store);
    logic [3:0] ea, eb;
    ea = use_aux ? aux_a : 4'h0;
    eb = use_aux ? aux_b : 4'h0;
    if (expect_store) sb.push_back({blk, din_b, eb, din_a, ea});
    send_sub(use_aux, aux_a, din_a, 1'b0, blk);
    send_sub(use_aux, aux_b, din_b, 1'b1, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    int waited;
    waited = 0;
    while (!dout_valid && waited < 10) begin
      tick();
      waited++;
    end
    if (!dout_valid) begin
      chk({tag, "_timeout"}, 64'(dout_valid), 64'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 64'(dout_valid), 64'd0);
    end else begin
      exp_word = sb.pop_front();
      chk(tag, 64'({dout_block, dout}), 64'(exp_word));
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
    end
  endtask

  initial begin
    #1;
    chk("reset_valid", 64'(dout_valid), 64'd0);
    chk("reset_fill", 64'(fill), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_mis", 64'(misalign_cnt), 64'd0);
    chk("reset_level", 64'(level), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1: basic pack with aux nibbles and two-cycle latency
    send_frame(1'b1, 4'hA, 20'h12345, 4'h5, 20'hABCDE, 1'b0, 1'b1);
    chk("t1_valid_push_cycle", 64'(dout_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(dout_valid), 64'd1);
    chk("t1_dout_const", 64'(dout), 64'hABCDE5_12345A);
    chk("t1_level", 64'(level), 64'h12);
    pop_check("t1_pop");
    chk("t1_empty", 64'(fill), 64'd0);

    // 2: overflow with consumer stalled
    for (int i = 0; i < 5; i++)
      send_frame(1'b1, 4'(i), 20'h10000 + 20'(i), 4'(i + 8), 20'h20000 + 20'(i), 1'b0, i < 4);
    tick();
    chk("t2_fill", 64'(fill), 64'd4);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_head", 64'({dout_block, dout}), 64'(sb[0]));

    // 3: pop in the same cycle as the push into a full FIFO
    sb.delete();
    do_reset();
    for (int i = 0; i < 4; i++)
      send_frame(1'b1, 4'(i + 1), 20'h30000 + 20'(i), 4'(i + 3), 20'h40000 + 20'(i), 1'b0, 1'b1);
    send_frame(1'b1, 4'hF, 20'h5A5A5, 4'h3, 20'hC3C3C, 1'b0, 1'b1);
    chk("t3_full_before", 64'(fill), 64'd4);
    exp_word = sb.pop_front();
    chk("t3_head_frame1", 64'({dout_block, dout}), 64'(exp_word));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("t3_fill", 64'(fill), 64'd4);
    chk("t3_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) pop_check("t3_drain");
    chk("t3_drained", 64'(fill), 64'd0);

    // 4: channel errors, resync, then saturation
    do_reset();
    send_sub(1'b0, 4'h0, 20'h11111, 1'b1, 1'b0);
    send_sub(1'b0, 4'h0, 20'h22222, 1'b0, 1'b0);
    sb.push_back({1'b0, 20'h44444, 4'h0, 20'h33333, 4'h0});
    send_sub(1'b0, 4'h0, 20'h33333, 1'b0, 1'b0);
    send_sub(1'b0, 4'h0, 20'h44444, 1'b1, 1'b0);
    tick();
    chk("t4_mis", 64'(misalign_cnt), 64'd2);
    chk("t4_fill", 64'(fill), 64'd1);
    pop_check("t4_pop");
    chk("t4_single", 64'(dout_valid), 64'd0);
    vin = 1'b1;
    in_channel = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    vin = 1'b0;
    tick();
    chk("t4_mis_sat", 64'(misalign_cnt), 64'd255);
    chk("t4_sat_nopush", 64'(fill), 64'd0);

    // 5: kill mid-frame, block flag, and kill during PUSH
    do_reset();
    send_sub(1'b1, 4'h7, 20'h77777, 1'b0, 1'b0);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    send_frame(1'b1, 4'h1, 20'h88888, 4'h2, 20'h99999, 1'b1, 1'b1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("t5_mis", 64'(misalign_cnt), 64'd0);
    chk("t5_fill", 64'(fill), 64'd1);
    chk("t5_block", 64'(dout_block), 64'd1);
    pop_check("t5_pop");
    chk("t5_empty", 64'(fill), 64'd0);

    // 6: reset with words queued and a frame being collected
    for (int i = 0; i < 3; i++)
      send_frame(1'b1, 4'h6, 20'h60000 + 20'(i), 4'h9, 20'h70000 + 20'(i), 1'b0, 1'b1);
    tick();
    chk("t6_fill_before", 64'(fill), 64'd3);
    send_sub(1'b1, 4'hB, 20'hBBBBB, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_rst_fill", 64'(fill), 64'd0);
    chk("t6_rst_valid", 64'(dout_valid), 64'd0);
    tick();
    chk("t6_rst_valid_clk", 64'(dout_valid), 64'd0);
    chk("t6_rst_level", 64'(level), 64'd0);
    rst = 1'b1;
    sb.delete();
    tick();
    send_frame(1'b0, 4'h0, 20'hFEDCB, 4'h0, 20'h01234, 1'b0, 1'b1);
    tick();
    chk("t6_fill_after", 64'(fill), 64'd1);
    chk("t6_level", 64'(level), 64'hFE);
    pop_check("t6_pop");
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
